// File: rtl/small_calc_pkg.sv
// Shared types and constants for the small calculator driver.
// Opcodes match the calculator encoding; the enum names the driver states.
package small_calc_pkg;

  localparam logic [1:0] OP_0 = 2'd0;
  localparam logic [1:0] OP_1 = 2'd1;
  localparam logic [1:0] OP_2 = 2'd2;
  localparam logic [1:0] OP_3 = 2'd3;

  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } drv_state_t;

endpackage

// File: rtl/small_calc_timer.sv
// WAIT-state watchdog: cleared in ISSUE, counts while enabled.
// Ports: CLK, RST_N, clear, enable in; expired out (count == LIMIT-1).
module small_calc_timer
  import small_calc_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(LIMIT + 1);

  logic [TW-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/small_calc_driver.sv
// Go/Done initiator for the small calculator: request in, response out.
// Ports: req_* / rsp_* valid-ready pair, calc_* to datapath, busy, op_count.
module small_calc_driver
  import small_calc_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_timeout,
  output logic         calc_go,
  output logic [1:0]   calc_op,
  output logic [W-1:0] calc_a,
  output logic [W-1:0] calc_b,
  input  logic         calc_done,
  input  logic [W-1:0] calc_result,
  output logic         busy,
  output logic [15:0]  op_count
);

  drv_state_t state;
  drv_state_t state_nxt;
  logic       expired;
  logic       tmr_clr;
  logic       tmr_en;

  small_calc_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      // done takes priority over a coincident expiry
      WAIT: begin
        if (calc_done)    state_nxt = RESP;
        else if (expired) state_nxt = RESP;
      end
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    calc_go   = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    tmr_clr   = (state == ISSUE);
    tmr_en    = (state == WAIT);
  end

  // operands stay put until the next accepted request
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      calc_op <= '0;
      calc_a  <= '0;
      calc_b  <= '0;
    end else if (state == IDLE && req_valid) begin
      calc_op <= req_op;
      calc_a  <= req_a;
      calc_b  <= req_b;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      op_count    <= '0;
    end else if (state == WAIT) begin
      if (calc_done) begin
        rsp_result  <= calc_result;
        rsp_timeout <= 1'b0;
        op_count    <= op_count + 16'd1;
      end else if (expired) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_small_calc_driver.sv
// Bench for small_calc_driver with a behavioural calculator model.
// Scenario tasks check latency, results, hold, timeout, reset and wrap.
module tb_small_calc_driver;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_timeout;
  logic         calc_go;
  logic [1:0]   calc_op;
  logic [W-1:0] calc_a;
  logic [W-1:0] calc_b;
  logic         calc_done = 1'b0;
  logic [W-1:0] calc_result = 8'hEE;
  logic         busy;
  logic [15:0]  op_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_count = '0;

  small_calc_driver #(.W(W), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .calc_go(calc_go), .calc_op(calc_op),
    .calc_a(calc_a), .calc_b(calc_b),
    .calc_done(calc_done), .calc_result(calc_result),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_calc(input logic [1:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      2'd0:    return a - b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a + b;
    endcase
  endfunction

  // Calculator model: done 5 edges after Go is sampled; no reset.
  int         m_cnt = 0;
  logic [7:0] m_res = '0;
  bit         model_en = 1'b1;
  bit         stray = 1'b0;

  always @(posedge clk) begin
    calc_done <= 1'b0;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        calc_done   <= 1'b1;
        calc_result <= m_res;
      end
    end
    if (stray) begin
      calc_done   <= 1'b1;
      calc_result <= 8'hA5;
      stray = 1'b0;
    end
    if (calc_go && model_en) begin
      m_cnt = 4;
      m_res = ref_calc(calc_op, calc_a, calc_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // caller sits at a negedge with the DUT idle
  task automatic send_req(input logic [1:0] op,
                          input logic [7:0] a,
                          input logic [7:0] b);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic [1:0] op,
                          input logic [7:0] a,
                          input logic [7:0] b,
                          output int lat,
                          output int gos,
                          output bit go0,
                          output bit stable);
    lat = 0;
    go0 = (calc_go === 1'b1);
    gos = go0 ? 1 : 0;
    stable = (calc_op === op && calc_a === a && calc_b === b);
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (calc_go === 1'b1) gos++;
      if (calc_op !== op || calc_a !== a || calc_b !== b) stable = 1'b0;
    end
    if (rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready, calc_go, rsp_valid, rsp_timeout, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 10000",
               {req_ready, calc_go, rsp_valid, rsp_timeout, busy});
    end
    n_chk++;
    if ({calc_op, calc_a, calc_b} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h want 0", {calc_op, calc_a, calc_b});
    end
    n_chk++;
    if (rsp_result !== 8'd0 || op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h/%h want 0/0", rsp_result, op_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b%b want 10", req_ready, busy);
    end
    exp_count = '0;
  endtask

  task automatic test_single;
    int lat, gos;
    bit go0, st;
    send_req(2'd3, 8'd12, 8'd5);
    n_chk++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got rdy=%b busy=%b want 0 1", req_ready, busy);
    end
    wait_rsp(2'd3, 8'd12, 8'd5, lat, gos, go0, st);
    exp_count++;
    n_chk++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 6", lat);
    end
    n_chk++;
    if (!go0 || gos !== 1) begin
      n_fail++;
      $display("FAIL single_go: got first=%0d count=%0d want 1 1", go0, gos);
    end
    n_chk++;
    if (rsp_result !== 8'd17 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got %0d/%b want 17/0", rsp_result, rsp_timeout);
    end
    n_chk++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL single_count: got %0d want %0d", op_count, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: got v=%b r=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat, gos;
    bit go0, st;
    int acc[4];
    logic [7:0] a, b, er;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      er = ref_calc(2'(i), a, b);
      send_req(2'(i), a, b);
      acc[i] = cyc;
      wait_rsp(2'(i), a, b, lat, gos, go0, st);
      exp_count++;
      n_chk++;
      if (lat !== 6 || !st || gos !== 1) begin
        n_fail++;
        $display("FAIL b2b_timing[%0d]: got lat=%0d stable=%0d go=%0d want 6 1 1",
                 i, lat, st, gos);
      end
      n_chk++;
      if (rsp_result !== er || rsp_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got %h/%b want %h/0", i, rsp_result, rsp_timeout, er);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (acc[i] - acc[i-1] !== 8) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 8", i, acc[i] - acc[i-1]);
      end
    end
    n_chk++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_timeout;
    int lat, gos;
    bit go0, st;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    model_en = 1'b0;
    send_req(2'd1, a, b);
    wait_rsp(2'd1, a, b, lat, gos, go0, st);
    n_chk++;
    if (lat !== TO + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 1);
    end
    n_chk++;
    if (rsp_result !== 8'd0 || rsp_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_result: got %h/%b want 00/1", rsp_result, rsp_timeout);
    end
    n_chk++;
    if (op_count !== exp_count || gos !== 1 || !st) begin
      n_fail++;
      $display("FAIL timeout_count: got cnt=%0d go=%0d st=%0d want %0d 1 1",
               op_count, gos, st, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_en = 1'b1;
  endtask

  task automatic test_hold;
    int lat, gos;
    bit go0, st, held;
    logic [7:0] a, b, er;
    a = 8'($urandom);
    b = 8'($urandom);
    er = ref_calc(2'd2, a, b);
    send_req(2'd2, a, b);
    wait_rsp(2'd2, a, b, lat, gos, go0, st);
    exp_count++;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) stray = 1'b1;
      if (i == 4) begin
        req_op = 2'd0;
        req_a = ~a;
        req_b = ~b;
        req_valid = 1'b1;
      end
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== er || req_ready !== 1'b0 ||
          rsp_timeout !== 1'b0 || op_count !== exp_count) held = 1'b0;
    end
    req_valid = 1'b0;
    n_chk++;
    if (lat !== 6 || !held) begin
      n_fail++;
      $display("FAIL hold_response: got lat=%0d held=%0d want 6 1", lat, held);
    end
    n_chk++;
    if (calc_op !== 2'd2 || calc_a !== a || calc_b !== b) begin
      n_fail++;
      $display("FAIL hold_operands: got %0d %h %h want 2 %h %h", calc_op, calc_a, calc_b, a, b);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== exp_count) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b busy=%b cnt=%0d want 0 0 %0d",
               rsp_valid, busy, op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid;
    int lat, gos;
    bit go0, st, quiet;
    logic [7:0] a, b, er;
    send_req(2'd3, 8'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_count = '0;
    n_chk++;
    if ({req_ready, calc_go, rsp_valid, busy} !== 4'b1000 ||
        {calc_op, calc_a, calc_b} !== 18'd0 || op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_values: got %b %h %0d want 1000 0 0",
               {req_ready, calc_go, rsp_valid, busy}, {calc_op, calc_a, calc_b}, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 ||
          rsp_result !== 8'd0) quiet = 1'b0;
    end
    n_chk++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL midreset_done_ignored: got %0d want 1", quiet);
    end
    a = 8'($urandom);
    b = 8'($urandom);
    er = ref_calc(2'd0, a, b);
    send_req(2'd0, a, b);
    wait_rsp(2'd0, a, b, lat, gos, go0, st);
    exp_count++;
    n_chk++;
    if (lat !== 6 || rsp_result !== er || op_count !== exp_count) begin
      n_fail++;
      $display("FAIL midreset_next: got lat=%0d res=%h cnt=%0d want 6 %h %0d",
               lat, rsp_result, op_count, er, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap;
    int lat, gos;
    bit go0, st;
    logic [7:0] a, b;
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    exp_count = 16'hFFFF;
    @(negedge clk);
    a = 8'($urandom);
    b = 8'($urandom);
    send_req(2'd1, a, b);
    wait_rsp(2'd1, a, b, lat, gos, go0, st);
    exp_count++;
    n_chk++;
    if (op_count !== exp_count || exp_count !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want %0d", op_count, exp_count);
    end
    n_chk++;
    if (rsp_result !== ref_calc(2'd1, a, b) || lat !== 6) begin
      n_fail++;
      $display("FAIL wrap_result: got %h lat=%0d want %h 6",
               rsp_result, lat, ref_calc(2'd1, a, b));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/small_calc_driver.md
# small_calc_driver

Initiator for the small calculator's Go/Done handshake. It accepts one operation request at a time on a valid/ready port, presents the operands and opcode to the calculator datapath, and pulses `calc_go`. It then waits for `calc_done`, captures the result, and returns it on a valid/ready response port; a timeout guards against a hung calculator. It sits between the host-side request source and the small calculator (control unit plus datapath).

## Interface
- `W`, 8: operand/result width.
- `TIMEOUT`, 16: max WAIT cycles before abort; legal range 6..255.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset; one clock, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: driver can accept; high only in IDLE.
- `req_op` in 2: calculator opcode, passed through unmodified.
- `req_a`, `req_b` in W: operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_result` out W: captured result; 0 on timeout.
- `rsp_timeout` out 1: response is a timeout abort.
- `calc_go` out 1: one-cycle start pulse to calculator.
- `calc_op` out 2: opcode to calculator.
- `calc_a`, `calc_b` out W: operands to calculator (in1/in2).
- `calc_done` in 1: calculator completion pulse, one cycle.
- `calc_result` in W: calculator output, valid while `calc_done`=1.
- `busy` out 1: state ≠ IDLE.
- `op_count` out 16: completed (non-timeout) operations, wraps at 16'hFFFF→0.

## Operation
- States:
  - IDLE:
    - `req_ready`=1.
    - `req_valid`=1 at an edge latches op/a/b into `calc_op`/`calc_a`/`calc_b` → ISSUE.
  - ISSUE:
    - `calc_go`=1 for exactly this one cycle.
    - Timer cleared → WAIT.
  - WAIT:
    - Timer increments each cycle.
    - `calc_done`=1 at an edge: capture `calc_result` into `rsp_result`, `rsp_timeout`=0, `op_count`+1 → RESP.
    - Otherwise, if timer reaches TIMEOUT−1: `rsp_result`=0, `rsp_timeout`=1 → RESP.
  - RESP:
    - `rsp_valid`=1; `rsp_result`/`rsp_timeout` held stable.
    - `rsp_ready`=1 at an edge → IDLE.
- `calc_op`/`calc_a`/`calc_b` hold stable from the latching edge until the next accepted request. The calculator samples operands during its load states, several cycles after Go.
- `calc_done` seen in IDLE, ISSUE or RESP is ignored: no capture, no count.
- `calc_done` and timeout expiry at the same edge: done wins, normal response.
- All outputs are registered; none is a combinational function of an input.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1.
  - `calc_go`=0, `calc_op`=0, `calc_a`=0, `calc_b`=0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_timeout`=0.
  - `busy`=0, `op_count`=0.
- Request accepted at edge k:
  - `calc_go` high in cycle k..k+1.
  - Calculator reaches completion 5 edges after sampling Go, so `calc_done` is high in cycle k+5..k+6.
  - `rsp_valid` rises after edge k+6.
  - Request-to-response latency: 6 cycles.
- Back-to-back: `rsp_ready`=1 on the first `rsp_valid` cycle returns to IDLE one edge later. The next request can be accepted at the following edge, so throughput is one op per 8 cycles.
- Timeout: with no `calc_done`, `rsp_valid` rises TIMEOUT+1 cycles after acceptance (ISSUE + TIMEOUT WAIT cycles).
- Reset mid-operation (any state):
  - All registers return to reset values immediately.
  - The calculator has no reset, so its in-flight `calc_done` may arrive later; it lands in IDLE and is ignored per above.
- `rsp_valid` never drops without `rsp_ready`; `calc_go` never asserts outside ISSUE.

## Structure
- Shared package `small_calc_pkg`:
  - opcode constants OP_0..OP_3 (2-bit), matching the calculator encoding.
  - driver state enum `drv_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - default `TIMEOUT` constant.
- One natural sub-module: `small_calc_timer`.
  - Ports: clear, enable, expiry compare; width $clog2(TIMEOUT+1).
  - Used in WAIT.
- Everything else stays flat in `small_calc_driver`.

## Test plan
- Reset then req op=3, a=8'd12, b=8'd5, with a calculator model returning 8'd17 → `calc_go` one cycle at k+1. `rsp_valid` at k+7 with `rsp_result`=17, `rsp_timeout`=0, `op_count`=1.
- Four back-to-back requests op=0..3, `rsp_ready` held 1 → four responses in order, 8 cycles apart, `op_count`=4. `calc_a`/`calc_b` stable throughout each WAIT.
- Model never asserts done, TIMEOUT=16 → `rsp_valid` 17 cycles after acceptance, `rsp_result`=0, `rsp_timeout`=1, `op_count` unchanged.
- `rsp_ready` held 0 for 10 cycles in RESP, with a stray `calc_done` and a new `req_valid` in that window → `rsp_valid`/`rsp_result` held, `req_ready`=0, no capture, count unchanged.
- `RST_N` pulled low in WAIT (cycle k+3), released, model done arrives at k+6 → outputs at reset values, done ignored, `op_count`=0, next request runs normally.
- `op_count` preloaded near wrap (65535 completions, or forced) → next completion wraps to 0.
